// File: rtl/jk_counter_pkg.sv
// rtl/jk_counter_pkg.sv - shared mode and JK code definitions for the JK counter bank
package jk_counter_pkg;

  typedef enum logic [1:0] {
    HOLD       = 2'b00,
    JK         = 2'b01,
    COUNT_UP   = 2'b10,
    COUNT_DOWN = 2'b11
  } mode_e;

  // {J,K} pair codes for one storage bit
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

endpackage

// File: rtl/jk_counter_ch.sv
// rtl/jk_counter_ch.sv - one channel: WIDTH JK bits or a modulo-MOD up/down counter
import jk_counter_pkg::*;

module jk_counter_ch #(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR,
  input  logic             en,
  input  mode_e            mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MOD - 1);
  // one bit wider so MOD == 2**WIDTH is representable for the out-of-range test
  localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MOD);

  logic [WIDTH-1:0] jk_next;
  logic [WIDTH-1:0] q_next;

  always_comb begin
    jk_next = q;
    for (int i = 0; i < WIDTH; i++) begin
      case ({j[i], k[i]})
        JK_HOLD: jk_next[i] = q[i];
        JK_RST:  jk_next[i] = 1'b0;
        JK_SET:  jk_next[i] = 1'b1;
        default: jk_next[i] = ~q[i];
      endcase
    end
  end

  always_comb begin
    tc = 1'b0;
    case (mode)
      COUNT_UP:   tc = en & (q >= MAX_Q);
      COUNT_DOWN: tc = en & (q == '0);
      default:    tc = 1'b0;
    endcase
  end

  always_comb begin
    q_next = q;
    case (mode)
      JK:         q_next = jk_next;
      COUNT_UP:   q_next = (q >= MAX_Q) ? '0 : q + 1'b1;
      COUNT_DOWN: q_next = (q == '0 || {1'b0, q} >= MOD_W) ? MAX_Q : q - 1'b1;
      default:    q_next = q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      q <= '0;
    end else if (CLR) begin
      q <= '0;
    end else if (en) begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/jk_counter_bank.sv
// rtl/jk_counter_bank.sv - NUM_CH-channel JK/counter bank; JKCB_CASCADE_EN chains channel enables
import jk_counter_pkg::*;

module jk_counter_bank #(
  parameter int WIDTH  = 4,
  parameter int NUM_CH = 4,
  parameter int MOD    = 10
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    CLR,
  input  logic                    EN,
  input  logic [1:0]              MODE,
  input  logic [NUM_CH*WIDTH-1:0] J,
  input  logic [NUM_CH*WIDTH-1:0] K,
  output logic [NUM_CH*WIDTH-1:0] Q,
  output logic [NUM_CH*WIDTH-1:0] QN,
  output logic [NUM_CH-1:0]       TC
);

  if (MOD < 2 || MOD > 2**WIDTH) begin : g_bad_mod
    $error("jk_counter_bank: MOD=%0d outside 2..2**WIDTH", MOD);
  end

  mode_e mode;
  assign mode = mode_e'(MODE);
  assign QN   = ~Q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic en_eff;
    logic ch_en;
    logic tc_c;

`ifdef JKCB_CASCADE_EN
    // each digit advances only when every lower digit is at its terminal count
    if (c == 0) begin : g_first
      assign en_eff = EN;
    end else begin : g_ripple
      assign en_eff = EN & g_ch[c-1].tc_c;
    end
`else
    assign en_eff = EN;
`endif

    // JK loads ignore the cascade so every digit can be written directly
    assign ch_en = (mode == JK) ? EN : en_eff;

    jk_counter_ch #(
      .WIDTH (WIDTH),
      .MOD   (MOD)
    ) u_ch (
      .CLK  (CLK),
      .RST  (RST),
      .CLR  (CLR),
      .en   (ch_en),
      .mode (mode),
      .j    (J[c*WIDTH +: WIDTH]),
      .k    (K[c*WIDTH +: WIDTH]),
      .q    (Q[c*WIDTH +: WIDTH]),
      .tc   (tc_c)
    );

    assign TC[c] = tc_c;
  end

endmodule
